rx_msg_controller: RTL

//  Sequences the UART receiver: drains bytes through the uld_rx_data/rx_empty handshake,

---
 rtl/rx_msg_pkg.sv | 21 ++
 rtl/rx_byte_unloader.sv | 52 +++++
 rtl/rx_msg_controller.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rx_msg_pkg.sv
// rx_msg_pkg: shared encodings for the UART message receiver.
// Frame FSM states, unloader states, default start-of-frame byte.
package rx_msg_pkg;

  typedef enum logic [2:0] {
    HUNT,
    BCNT,
    BODY,
    CKSUM,
    HOLD
  } frm_st_t;

  typedef enum logic [1:0] {
    U_IDLE,
    U_WAIT,
    U_CAP
  } uld_st_t;

  localparam logic [7:0] SOF_DEFAULT = 8'h7E;

endpackage

// File: rtl/rx_byte_unloader.sv
// rx_byte_unloader: 3-cycle uart unload handshake, one byte per pass.
// Ports: ct_rxclk, reset (async low), rx_empty/rx_data in,
// hold in (no strobes while set), uld_rx_data, byte_q, byte_v out.
module rx_byte_unloader
  import rx_msg_pkg::*;
(
  input  logic       ct_rxclk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  input  logic       hold,
  output logic       uld_rx_data,
  output logic [7:0] byte_q,
  output logic       byte_v
);

  uld_st_t st_q, st_d;

  // rx_data is valid from the cycle after the strobe, so the
  // register is loaded leaving U_WAIT and is stable during U_CAP.
  always_ff @(posedge ct_rxclk or negedge reset) begin
    if (!reset) begin
      st_q   <= U_IDLE;
      byte_q <= 8'h00;
    end else begin
      st_q <= st_d;
      if (st_q == U_WAIT) byte_q <= rx_data;
    end
  end

  // reset gates the strobe so it is 0 while reset is held.
  always_comb begin
    st_d        = st_q;
    uld_rx_data = 1'b0;
    byte_v      = 1'b0;
    unique case (st_q)
      U_IDLE: begin
        if (!rx_empty && !hold && reset) begin
          uld_rx_data = 1'b1;
          st_d        = U_WAIT;
        end
      end
      U_WAIT: st_d = U_CAP;
      U_CAP: begin
        byte_v = 1'b1;
        st_d   = U_IDLE;
      end
      default: st_d = U_IDLE;
    endcase
  end

endmodule

// File: rtl/rx_msg_controller.sv
// rx_msg_controller: frames uart bytes as [SOF][COUNT][BODY]([CKSUM])
// and holds one message for a consumer with valid/ack.
// Ports: ct_rxclk, reset (async low); uart rx_empty/rx_data/uld_rx_data;
// msg_valid/msg_ack/msg_len/msg_rd_idx/msg_rd_data;
// err_timeout/err_len/err_cksum pulses.
// Option: RX_CKSUM_EN adds a trailing checksum byte.
module rx_msg_controller
  import rx_msg_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
  parameter int         MAX_BYTES   = 10,
  parameter int         LEN_W       = 4,
  parameter int         TIMEOUT_CYC = 100
) (
  input  logic             ct_rxclk,
  input  logic             reset,
  input  logic             rx_empty,
  input  logic [7:0]       rx_data,
  output logic             uld_rx_data,
  output logic             msg_valid,
  input  logic             msg_ack,
  output logic [LEN_W-1:0] msg_len,
  input  logic [LEN_W-1:0] msg_rd_idx,
  output logic [7:0]       msg_rd_data,
  output logic             err_timeout,
  output logic             err_len,
  output logic             err_cksum
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] MAX8 = 8'(MAX_BYTES);

  frm_st_t st_q, st_d;

  logic [7:0]       byte_q;
  logic             byte_v;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] idx;
  logic [TW-1:0]    timer;
  logic [7:0]       mem [MAX_BYTES];

  logic clr, ld_cnt, wr;
  logic to_d, len_d;
  logic in_frame, tmo_hit, len_bad, last;

  rx_byte_unloader u_uld (
    .ct_rxclk    (ct_rxclk),
    .reset       (reset),
    .rx_empty    (rx_empty),
    .rx_data     (rx_data),
    .hold        (st_q == HOLD),
    .uld_rx_data (uld_rx_data),
    .byte_q      (byte_q),
    .byte_v      (byte_v)
  );

  assign in_frame = (st_q == BCNT) ||
                    (st_q == BODY) ||
                    (st_q == CKSUM);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_hit  = in_frame && !byte_v &&
                    (timer == T_LAST);
  assign len_bad  = (byte_q == 8'd0) || (byte_q > MAX8);
  assign last     = (idx == cnt - LEN_W'(1));

`ifdef RX_CKSUM_EN
  logic [7:0] sum;
  logic       ck_d;
`endif

  always_comb begin
    st_d   = st_q;
    clr    = 1'b0;
    ld_cnt = 1'b0;
    wr     = 1'b0;
    to_d   = 1'b0;
    len_d  = 1'b0;
`ifdef RX_CKSUM_EN
    ck_d   = 1'b0;
`endif
    if (tmo_hit) begin
      st_d = HUNT;
      to_d = 1'b1;
    end else begin
      unique case (st_q)
        HUNT: begin
          if (byte_v && byte_q == SOF_BYTE) begin
            st_d = BCNT;
            clr  = 1'b1;
          end
        end
        BCNT: begin
          if (byte_v) begin
            if (len_bad) begin
              st_d  = HUNT;
              len_d = 1'b1;
            end else begin
              st_d   = BODY;
              ld_cnt = 1'b1;
            end
          end
        end
        BODY: begin
          if (byte_v) begin
            wr = 1'b1;
`ifdef RX_CKSUM_EN
            if (last) st_d = CKSUM;
`else
            if (last) st_d = HOLD;
`endif
          end
        end
`ifdef RX_CKSUM_EN
        CKSUM: begin
          if (byte_v) begin
            if (byte_q == sum) begin
              st_d = HOLD;
            end else begin
              st_d = HUNT;
              ck_d = 1'b1;
            end
          end
        end
`endif
        HOLD: begin
          if (msg_ack) st_d = HUNT;
        end
        default: st_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge ct_rxclk or negedge reset) begin
    if (!reset) begin
      st_q        <= HUNT;
      cnt         <= '0;
      idx         <= '0;
      timer       <= '0;
      err_timeout <= 1'b0;
      err_len     <= 1'b0;
      for (int i = 0; i < MAX_BYTES; i++)
        mem[i] <= 8'h00;
    end else begin
      st_q        <= st_d;
      err_timeout <= to_d;
      err_len     <= len_d;
      if (clr) begin
        cnt <= '0;
        idx <= '0;
      end
      if (ld_cnt) cnt <= byte_q[LEN_W-1:0];
      if (wr) begin
        mem[idx] <= byte_q;
        idx      <= idx + 1'b1;
      end
      if (byte_v || !in_frame || tmo_hit)
        timer <= '0;
      else
        timer <= timer + 1'b1;
    end
  end

`ifdef RX_CKSUM_EN
  always_ff @(posedge ct_rxclk or negedge reset) begin
    if (!reset) begin
      sum       <= 8'h00;
      err_cksum <= 1'b0;
    end else begin
      err_cksum <= ck_d;
      if (clr)
        sum <= 8'h00;
      else if (wr)
        sum <= sum + byte_q;
    end
  end
`else
  assign err_cksum = 1'b0;
`endif

  assign msg_valid   = (st_q == HOLD);
  assign msg_len     = msg_valid ? cnt : '0;
  assign msg_rd_data = (msg_rd_idx < msg_len) ?
                       mem[msg_rd_idx] : 8'h00;

endmodule
